// File: rtl/fpga_cfg_loader_if.sv
// Host-side configuration stream and readback bus of the bitstream loader.
interface fpga_cfg_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    // Host side: supplies config words, receives readback words
    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready,
        input  rd_data,
        input  rd_valid
    );

    // Loader side
    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/fpga_cfg_loader.sv
// Word-stream bitstream loader: shifts host words LSB first into the CLB scan
// chain and then the connection scan chain, repacking the bits that fall out
// of the chain tails into readback words.
module fpga_cfg_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLB_CHAIN_LEN  = 20,
    parameter int CONN_CHAIN_LEN = 44,
    parameter int CNT_WIDTH      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    fpga_cfg_loader_if.slave   host,
    output logic               clb_scan_in,
    output logic               clb_scan_en,
    input  logic               clb_scan_out,
    output logic               conn_scan_in,
    output logic               conn_scan_en,
    input  logic               conn_scan_out,
    output logic               scan_shift,
    output logic               busy,
    output logic               done
);
    localparam int SW = $clog2(DATA_WIDTH + 1);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CLB_LEN  = CNT_WIDTH'(CLB_CHAIN_LEN);
    localparam logic [CNT_WIDTH-1:0] CONN_LEN = CNT_WIDTH'(CONN_CHAIN_LEN);
    localparam logic [CNT_WIDTH-1:0] DW_CNT   = CNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD_CLB, LOAD_CONN, DONE} state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] buf_reg;       // word being shifted out, LSB next
    logic [DATA_WIDTH-1:0] rb_reg;        // readback bits collected so far
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [SW-1:0]         burst_reg;     // shifts left in the current word
    logic [IW-1:0]         rb_idx_reg;    // bit position of the next readback bit
    logic [CNT_WIDTH-1:0]  bit_cnt_reg;   // bits already shifted into the active chain
    logic                  cfg_ready_reg;
    logic                  rd_valid_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  clb_en_reg;
    logic                  conn_en_reg;

    logic [CNT_WIDTH-1:0]  chain_len;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  word_bits;
    logic                  tail_bit;
    logic [DATA_WIDTH-1:0] rb_next;
    logic                  shifting;
    logic                  last_shift;
    logic                  chain_end;

    // Active-chain bookkeeping: word size to shift and end-of-word/end-of-chain flags
    always_comb begin
        chain_len  = (state_reg == LOAD_CONN) ? CONN_LEN : CLB_LEN;
        remaining  = chain_len - bit_cnt_reg;
        word_bits  = (remaining < DW_CNT) ? remaining : DW_CNT;
        tail_bit   = (state_reg == LOAD_CONN) ? conn_scan_out : clb_scan_out;
        rb_next    = rb_reg;
        rb_next[rb_idx_reg] = tail_bit;
        shifting   = clb_en_reg | conn_en_reg;
        last_shift = shifting && (burst_reg == SW'(1));
        chain_end  = (bit_cnt_reg + CNT_WIDTH'(1)) == chain_len;
    end

    // Load sequencer: handshake, per-bit shifting, readback packing and chain switching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            buf_reg       <= '0;
            rb_reg        <= '0;
            rd_data_reg   <= '0;
            burst_reg     <= '0;
            rb_idx_reg    <= '0;
            bit_cnt_reg   <= '0;
            cfg_ready_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            clb_en_reg    <= 1'b0;
            conn_en_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            if (abort) begin
                // A partially collected readback word is simply never published
                state_reg     <= IDLE;
                cfg_ready_reg <= 1'b0;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b0;
                clb_en_reg    <= 1'b0;
                conn_en_reg   <= 1'b0;
                burst_reg     <= '0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start) begin
                            state_reg     <= LOAD_CLB;
                            done_reg      <= 1'b0;
                            busy_reg      <= 1'b1;
                            cfg_ready_reg <= 1'b1;
                            bit_cnt_reg   <= '0;
                            burst_reg     <= '0;
                            rb_idx_reg    <= '0;
                        end
                    end
                    default: begin
                        if (cfg_ready_reg && host.cfg_valid) begin
                            buf_reg       <= host.cfg_data;
                            burst_reg     <= SW'(word_bits);
                            rb_reg        <= '0;
                            rb_idx_reg    <= '0;
                            cfg_ready_reg <= 1'b0;
                            clb_en_reg    <= (state_reg == LOAD_CLB);
                            conn_en_reg   <= (state_reg == LOAD_CONN);
                        end else if (shifting) begin
                            buf_reg     <= buf_reg >> 1;
                            burst_reg   <= burst_reg - SW'(1);
                            bit_cnt_reg <= bit_cnt_reg + CNT_WIDTH'(1);
                            rb_reg      <= rb_next;
                            rb_idx_reg  <= rb_idx_reg + IW'(1);
                            if (last_shift) begin
                                clb_en_reg   <= 1'b0;
                                conn_en_reg  <= 1'b0;
                                rd_data_reg  <= rb_next;
                                rd_valid_reg <= 1'b1;
                                if (chain_end) begin
                                    // Next chain starts on a fresh word
                                    bit_cnt_reg <= '0;
                                    if (state_reg == LOAD_CLB) begin
                                        state_reg     <= LOAD_CONN;
                                        cfg_ready_reg <= 1'b1;
                                    end else begin
                                        state_reg <= DONE;
                                        busy_reg  <= 1'b0;
                                        done_reg  <= 1'b1;
                                    end
                                end else begin
                                    cfg_ready_reg <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign host.cfg_ready = cfg_ready_reg;
    assign host.rd_data   = rd_data_reg;
    assign host.rd_valid  = rd_valid_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign scan_shift     = shifting;
    assign clb_scan_en    = clb_en_reg;
    assign conn_scan_en   = conn_en_reg;
    // The idle chain always sees a 0 on its input
    assign clb_scan_in    = clb_en_reg & buf_reg[0];
    assign conn_scan_in   = conn_en_reg & buf_reg[0];
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: random word streams against a queue-based model of
// the two scan chains, with a negedge monitor draining the expected-bit and
// expected-readback queues.
module tb_fpga_cfg_loader;
    localparam int DW        = 8;
    localparam int CLB_LEN   = 20;
    localparam int CONN_LEN  = 12;
    localparam int CNT_W     = 16;
    localparam int CLB_WORDS = (CLB_LEN + DW - 1) / DW;
    localparam int PERIOD    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic clb_scan_in, clb_scan_en, clb_scan_out;
    logic conn_scan_in, conn_scan_en, conn_scan_out;
    logic scan_shift, busy, done;

    fpga_cfg_loader_if #(.DATA_WIDTH(DW)) host_if ();

    fpga_cfg_loader #(
        .DATA_WIDTH(DW), .CLB_CHAIN_LEN(CLB_LEN),
        .CONN_CHAIN_LEN(CONN_LEN), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .host(host_if),
        .clb_scan_in(clb_scan_in), .clb_scan_en(clb_scan_en), .clb_scan_out(clb_scan_out),
        .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en), .conn_scan_out(conn_scan_out),
        .scan_shift(scan_shift), .busy(busy), .done(done)
    );

    always #(PERIOD / 2) clk = ~clk;

    // Fabric scan chains: bits enter at index 0, tail is the top index
    logic [CLB_LEN-1:0]  clb_chain, pre_clb;
    logic [CONN_LEN-1:0] conn_chain, pre_conn;
    logic                preload = 1'b1;
    assign clb_scan_out  = clb_chain[CLB_LEN-1];
    assign conn_scan_out = conn_chain[CONN_LEN-1];

    always @(posedge clk) begin
        if (preload) begin
            clb_chain  <= pre_clb;
            conn_chain <= pre_conn;
        end else begin
            if (scan_shift && clb_scan_en)
                clb_chain <= {clb_chain[CLB_LEN-2:0], clb_scan_in};
            if (scan_shift && conn_scan_en)
                conn_chain <= {conn_chain[CONN_LEN-2:0], conn_scan_in};
        end
    end

    // Reference model: chain contents as queues, front = bit at the tail
    bit              mdl_clb[$], mdl_conn[$];
    bit              exp_clb[$], exp_conn[$];
    logic [DW-1:0]   exp_rd[$];
    logic [DW-1:0]   words[$];
    int              vectors = 0;
    int              miscompares = 0;
    int              shift_pulses = 0;
    int              rd_count = 0;
    time             last_shift_time = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected bits presented to one chain and readback words it returns,
    // when shift_n of its len bits get shifted from words[first_word...]
    task automatic model_chain_load(input bit is_conn, input int first_word,
                                    input int len, input int shift_n);
        int nwords, nb, got_bits, pos;
        logic [DW-1:0] rb;
        bit b, o;
        nwords = (len + DW - 1) / DW;
        for (int w = 0; w < nwords; w++) begin
            nb = (len - w * DW < DW) ? (len - w * DW) : DW;
            rb = '0;
            got_bits = 0;
            for (int k = 0; k < nb; k++) begin
                pos = w * DW + k;
                if (pos < shift_n) begin
                    b = words[first_word + w][k];
                    if (is_conn) begin
                        exp_conn.push_back(b);
                        o = mdl_conn.pop_front();
                        mdl_conn.push_back(b);
                    end else begin
                        exp_clb.push_back(b);
                        o = mdl_clb.pop_front();
                        mdl_clb.push_back(b);
                    end
                    rb[k] = o;
                    got_bits++;
                end
            end
            if (got_bits == nb) exp_rd.push_back(rb);
        end
    endtask

    task automatic expect_full_load();
        model_chain_load(1'b0, 0, CLB_LEN, CLB_LEN);
        model_chain_load(1'b1, CLB_WORDS, CONN_LEN, CONN_LEN);
    endtask

    task automatic random_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(DW'($urandom));
    endtask

    // Monitor: every shift cycle and every readback pulse is checked against the queues
    always @(negedge clk) begin
        bit e;
        logic [DW-1:0] er;
        if (rst_n) begin
            check("shift_strobe", 64'(scan_shift), 64'(clb_scan_en ^ conn_scan_en));
            if (scan_shift) begin
                shift_pulses++;
                last_shift_time = $time;
            end
            if (clb_scan_en) begin
                if (exp_clb.size() == 0) begin
                    check("clb_unexpected_shift", 64'(clb_scan_en), 64'(0));
                end else begin
                    e = exp_clb.pop_front();
                    check("clb_scan_in", 64'(clb_scan_in), 64'(e));
                end
                check("conn_idle_in", 64'(conn_scan_in), 64'(0));
            end
            if (conn_scan_en) begin
                if (exp_conn.size() == 0) begin
                    check("conn_unexpected_shift", 64'(conn_scan_en), 64'(0));
                end else begin
                    e = exp_conn.pop_front();
                    check("conn_scan_in", 64'(conn_scan_in), 64'(e));
                end
                check("clb_idle_in", 64'(clb_scan_in), 64'(0));
            end
            if (host_if.rd_valid) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 64'(host_if.rd_valid), 64'(0));
                end else begin
                    er = exp_rd.pop_front();
                    $display("rd word %0d: got 0x%02h expected 0x%02h", rd_count, host_if.rd_data, er);
                    check("rd_data", 64'(host_if.rd_data), 64'(er));
                    rd_count++;
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one word until accepted, then optionally drop valid for gap cycles
    task automatic send_word(input logic [DW-1:0] w, input int gap);
        int t;
        host_if.cfg_data  = w;
        host_if.cfg_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!host_if.cfg_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!host_if.cfg_ready) begin
            check("handshake_timeout", 64'(host_if.cfg_ready), 64'(1));
            host_if.cfg_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (gap > 0) begin
            host_if.cfg_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_all(input int gap_min, input int gap_max);
        for (int i = 0; i < words.size(); i++)
            send_word(words[i], int'($urandom_range(gap_max, gap_min)));
        host_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done"}, 64'(done), 64'(1));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_ready_in_done"}, 64'(host_if.cfg_ready), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        check(name, {host_if.rd_data, host_if.cfg_ready, clb_scan_in, clb_scan_en,
                     conn_scan_in, conn_scan_en, scan_shift, host_if.rd_valid, busy, done}, 64'(0));
    endtask

    initial begin
        int p0, cnt;
        host_if.cfg_data  = '0;
        host_if.cfg_valid = 1'b0;
        pre_clb  = CLB_LEN'($urandom);
        pre_conn = CONN_LEN'($urandom);
        for (int i = CLB_LEN - 1; i >= 0; i--) mdl_clb.push_back(pre_clb[i]);
        for (int i = CONN_LEN - 1; i >= 0; i--) mdl_conn.push_back(pre_conn[i]);

        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");

        // Directed alignment load with cfg_valid held high
        words.delete();
        words.push_back(8'hA5); words.push_back(8'h3C); words.push_back(8'hFF);
        words.push_back(8'h81); words.push_back(8'h0F);
        expect_full_load();
        p0 = shift_pulses;
        $display("load directed: 5 words, valid held high");
        pulse_start();
        check("busy_after_start", 64'(busy), 64'(1));
        send_all(0, 0);
        wait_done("directed");
        check("done_one_cycle_after_last_shift", 64'($time - last_shift_time), 64'(PERIOD));
        check("directed_shift_count", 64'(shift_pulses - p0), 64'(CLB_LEN + CONN_LEN));

        // cfg_valid in DONE is ignored
        host_if.cfg_valid = 1'b1;
        host_if.cfg_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        host_if.cfg_valid = 1'b0;
        check("ready_in_done", 64'(host_if.cfg_ready), 64'(0));
        check("done_sticky", 64'(done), 64'(1));

        // Restart from DONE with a throttled source and a stray start mid-load
        random_words(5);
        expect_full_load();
        $display("load throttled: restart from done, gaps of 5..14 cycles");
        pulse_start();
        check("done_cleared_on_restart", 64'(done), 64'(0));
        check("busy_on_restart", 64'(busy), 64'(1));
        send_word(words[0], 5);
        pulse_start();
        for (int i = 1; i < 5; i++) send_word(words[i], int'($urandom_range(14, 5)));
        host_if.cfg_valid = 1'b0;
        wait_done("throttled");

        // Random loads with small random gaps
        for (int l = 0; l < 4; l++) begin
            random_words(5);
            expect_full_load();
            $display("load random %0d: words %02h %02h %02h %02h %02h", l,
                     words[0], words[1], words[2], words[3], words[4]);
            pulse_start();
            send_all(0, 3);
            wait_done("random");
        end

        // Abort in LOAD_CONN in the cycle of the 4th connection shift
        random_words(4);
        model_chain_load(1'b0, 0, CLB_LEN, CLB_LEN);
        model_chain_load(1'b1, CLB_WORDS, CONN_LEN, 4);
        $display("load abort: abort after 4 connection bits");
        pulse_start();
        send_all(0, 0);
        cnt = 0;
        for (int t = 0; t < 100 && cnt < 4; t++) begin
            @(negedge clk);
            if (conn_scan_en) cnt++;
        end
        check("abort_reached_4_bits", 64'(cnt), 64'(4));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_ready", 64'(host_if.cfg_ready), 64'(0));
        check("abort_shift", 64'(scan_shift), 64'(0));
        repeat (5) @(posedge clk);
        #1;

        // start together with abort stays in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'(0));
        check("start_abort_ready", 64'(host_if.cfg_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("start_abort_still_idle", 64'(busy), 64'(0));

        // Full reload after abort starts again from CLB bit 0
        random_words(5);
        expect_full_load();
        $display("load after abort: full reload");
        pulse_start();
        send_all(0, 2);
        wait_done("reload");

        // Reset in the 3rd CLB shift cycle: that bit is presented but never shifted
        random_words(5);
        model_chain_load(1'b0, 0, CLB_LEN, 2);
        exp_clb.push_back(words[0][2]);
        $display("load reset: rst_n asserted in the 3rd CLB shift cycle");
        pulse_start();
        send_word(words[0], 0);
        cnt = 0;
        for (int t = 0; t < 50 && cnt < 3; t++) begin
            @(negedge clk);
            if (clb_scan_en) cnt++;
        end
        check("reset_reached_3rd_shift", 64'(cnt), 64'(3));
        #2;
        rst_n = 1'b0;
        host_if.cfg_valid = 1'b0;
        #1;
        check_all_zero("reset_mid_load_outputs");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = shift_pulses;
        repeat (30) @(posedge clk);
        #1;
        check("no_shift_after_reset", 64'(shift_pulses - p0), 64'(0));
        check("idle_after_reset_release", 64'(busy), 64'(0));

        // Recovery load after reset
        random_words(5);
        expect_full_load();
        $display("load after reset: full load");
        pulse_start();
        send_all(0, 1);
        wait_done("post_reset");
        repeat (3) @(posedge clk);
        #1;

        check("clb_bits_left", 64'(exp_clb.size()), 64'(0));
        check("conn_bits_left", 64'(exp_conn.size()), 64'(0));
        check("rd_words_left", 64'(exp_rd.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
